mac_drain: RTL

MAC_DRAIN -- requirements
Module: mac_drain

---
 rtl/mac_pkg.sv | 25 ++
 rtl/mac_requant.sv | 56 +++++
 rtl/mac_drain.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_pkg
//  Purpose  : Shared constants for the MAC drain controller: the controller
//             state encoding and the drain latency (number of clock edges
//             between the last accepted term and the result capture).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Controller state encoding
    localparam int          C_ST_W       = 2;
    localparam logic [1:0]  C_ST_ACCUM   = 2'd0;
    localparam logic [1:0]  C_ST_DRAIN   = 2'd1;
    localparam logic [1:0]  C_ST_CAPTURE = 2'd2;
    localparam logic [1:0]  C_ST_CLEAR   = 2'd3;

    // Edges from the last accepted term to the capture edge; this covers the
    // pipeline depth of the external multiply-accumulator.
    localparam int C_DRAIN_CYCLES = 5;
    localparam int C_CNT_W        = $clog2(C_DRAIN_CYCLES + 1);

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_requant.sv
`default_nettype none
// ============================================================================
//  Module   : mac_requant
//  Purpose  : Combinational requantiser. Treats the accumulator as signed,
//             optionally rounds half-up and arithmetic-shifts right by
//             i_shift, then saturates to a signed OUT_WIDTH result.
//  Ports    : i_acc   [ACC_W]       signed accumulator value
//             i_shift [SHIFT_WIDTH] right-shift amount (< ACC_W)
//             o_data  [OUT_WIDTH]   scaled, saturated result
//             o_sat                 high when the result was clipped
//  Revision : 1.0 - initial release
// ============================================================================
module mac_requant #(
    parameter int ACC_W       = 33,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic [ACC_W-1:0]       i_acc,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    output logic [OUT_WIDTH-1:0]   o_data,
    output logic                   o_sat
);

    // One guard bit above the accumulator so adding the rounding constant
    // can never overflow.
    logic signed [ACC_W:0]         w_ext;
    logic signed [ACC_W:0]         w_rnd;
    logic signed [ACC_W:0]         w_sum;
    logic signed [ACC_W:0]         w_shr;
    // Bits that must all equal the sign for the value to fit in OUT_WIDTH
    logic [ACC_W-OUT_WIDTH+1:0]    w_hi;

    always_comb begin
        w_ext = $signed({i_acc[ACC_W-1], i_acc});
        w_rnd = '0;
        if (i_shift != '0) begin
            w_rnd = (ACC_W+1)'(1) << (i_shift - SHIFT_WIDTH'(1));
        end
        w_sum = w_ext + w_rnd;
        w_shr = w_sum >>> i_shift;
        w_hi  = w_shr[ACC_W:OUT_WIDTH-1];

        o_data = w_shr[OUT_WIDTH-1:0];
        o_sat  = 1'b0;
        if ((w_hi != '0) && (w_hi != '1)) begin
            o_sat = 1'b1;
            if (w_shr[ACC_W]) begin
                o_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                o_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end
    end

endmodule : mac_requant
`default_nettype wire

// File: rtl/mac_drain.sv
`default_nettype none
// ============================================================================
//  Module   : mac_drain
//  Purpose  : Stream controller around an external multiply-accumulator.
//             Accepts image/kernel terms, waits for the MAC pipeline to drain
//             after the last term, captures the requantised result into a
//             single output slot, then pulses a clear to the MAC.
//  Ports    : clk, rst (async, active high)
//             in_img/in_ker/in_val/in_last/in_rdy  term input handshake
//             mac_img/mac_ker/mac_val              terms forwarded to the MAC
//             mac_clr                              registered MAC clear
//             mac_result [ACC_W]                   MAC accumulator output
//             cfg_shift                            right-shift amount
//             out_data/out_sat/out_val/out_rdy     result output handshake
//  Revision : 1.0 - initial release
// ============================================================================
module mac_drain
    import mac_pkg::*;
#(
    parameter int IMG_WIDTH   = 16,
    parameter int KER_WIDTH   = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6,
    localparam int ACC_W      = IMG_WIDTH + KER_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IMG_WIDTH-1:0]   in_img,
    input  logic [KER_WIDTH-1:0]   in_ker,
    input  logic                   in_val,
    input  logic                   in_last,
    output logic                   in_rdy,
    output logic [IMG_WIDTH-1:0]   mac_img,
    output logic [KER_WIDTH-1:0]   mac_ker,
    output logic                   mac_val,
    output logic                   mac_clr,
    input  logic [ACC_W-1:0]       mac_result,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic                   out_val,
    input  logic                   out_rdy
);

    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(C_DRAIN_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    logic [C_ST_W-1:0]    r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_mac_clr;
    logic                 r_out_val;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_sat;

    logic                 w_accept;
    logic                 w_drain_done;
    logic                 w_slot_free;
    logic                 w_capture;
    logic [OUT_WIDTH-1:0] w_q_data;
    logic                 w_q_sat;

    mac_requant #(
        .ACC_W       (ACC_W),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .i_acc   (mac_result),
        .i_shift (cfg_shift),
        .o_data  (w_q_data),
        .o_sat   (w_q_sat)
    );

    assign in_rdy   = (r_state == C_ST_ACCUM);
    assign w_accept = in_val & in_rdy;
    assign mac_img  = in_img;
    assign mac_ker  = in_ker;
    assign mac_val  = w_accept;
    assign mac_clr  = r_mac_clr;
    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;
    assign out_val  = r_out_val;

    // The slot can take a new result when empty or being emptied this cycle.
    assign w_slot_free  = ~r_out_val | out_rdy;
    // Edge at which the drain count reaches zero.
    assign w_drain_done = (r_state == C_ST_DRAIN) && (r_cnt == C_CNT_ONE);
    // The edge where the count reaches zero is itself the capture edge when
    // the slot is free, so the result lands exactly C_DRAIN_CYCLES edges after
    // the last term. Otherwise the controller parks in CAPTURE until it frees.
    assign w_capture    = (w_drain_done || (r_state == C_ST_CAPTURE)) && w_slot_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= C_ST_ACCUM;
            r_cnt      <= '0;
            r_mac_clr  <= 1'b0;
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            r_mac_clr <= 1'b0;

            if (r_out_val && out_rdy) begin
                r_out_val <= 1'b0;
            end

            // cfg_shift only matters here: the requantiser output is sampled
            // on the capture edge and nowhere else.
            if (w_capture) begin
                r_out_data <= w_q_data;
                r_out_sat  <= w_q_sat;
                r_out_val  <= 1'b1;
            end

            case (r_state)
                C_ST_ACCUM: begin
                    if (w_accept && in_last) begin
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= C_ST_DRAIN;
                    end
                end
                C_ST_DRAIN: begin
                    r_cnt <= r_cnt - C_CNT_ONE;
                    if (w_drain_done) begin
                        if (w_capture) begin
                            r_mac_clr <= 1'b1;
                            r_state   <= C_ST_CLEAR;
                        end else begin
                            r_state   <= C_ST_CAPTURE;
                        end
                    end
                end
                C_ST_CAPTURE: begin
                    if (w_capture) begin
                        r_mac_clr <= 1'b1;
                        r_state   <= C_ST_CLEAR;
                    end
                end
                C_ST_CLEAR: begin
                    r_state <= C_ST_ACCUM;
                end
                default: begin
                    r_state <= C_ST_ACCUM;
                end
            endcase
        end
    end

endmodule : mac_drain
`default_nettype wire
